// File: rtl/rexta_muldiv.sv
// rexta_muldiv: iterative RV32M multiply/divide unit.
//   Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//   Division by zero and signed overflow complete immediately.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op                   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   req_a, req_b             rs1 / rs2 operands
//   flush                    abort any operation, discard result
//   resp_valid/resp_ready    response handshake
//   resp_result              result, held until the next completion
module rexta_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t              state, state_nx;
  logic [2:0]          op_q;
  logic [2*XLEN-1:0]   acc;     // product accumulator; low half holds dividend/quotient
  logic [XLEN:0]       rem;     // partial remainder
  logic [XLEN-1:0]     opnd;    // multiplicand or divisor magnitude
  logic                neg_q;   // negate the selected result in FIXUP
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     result;

  // Request decode
  logic            is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] ma, mb;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div      = req_op[2];
    a_signed    = (req_op == 3'b001) || (req_op == 3'b010) ||
                  (req_op == 3'b100) || (req_op == 3'b110);
    b_signed    = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
    sa          = a_signed & req_a[XLEN-1];
    sb          = b_signed & req_b[XLEN-1];
    ma          = sa ? (~req_a + 1'b1) : req_a;
    mb          = sb ? (~req_b + 1'b1) : req_b;
    div_zero    = (req_b == '0);
    div_ovf     = ~req_op[0] && (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);
    special     = is_div && (div_zero || div_ovf);
    special_res = '0;
    if (div_zero)
      special_res = req_op[1] ? req_a : '1;
    else
      special_res = req_op[1] ? '0 : req_a;
    accept      = req_valid && (state == IDLE) && !flush;
  end

  // One iteration step
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fixup_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    prod_fix  = neg_q ? (~acc + 1'b1) : acc;
    quo_fix   = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix   = neg_q ? (~rem[XLEN-1:0] + 1'b1) : rem[XLEN-1:0];
    fixup_res = '0;
    case (op_q)
      3'b000:                 fixup_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fixup_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fixup_res = quo_fix;
      default:                fixup_res = rem_fix;
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid) state_nx = special ? DONE : BUSY;
        BUSY:    if (cnt == '0) state_nx = FIXUP;
        FIXUP:   state_nx = DONE;
        DONE:    if (resp_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= req_op;
      cnt   <= CW'(XLEN - 1);
      rem   <= '0;
      opnd  <= is_div ? mb : ma;
      acc   <= {{XLEN{1'b0}}, (is_div ? ma : mb)};
      neg_q <= (is_div && req_op[1]) ? sa : (sa ^ sb);
      if (special) result <= special_res;
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          rem            <= div_diff;
          acc[XLEN-1:0]  <= {acc[XLEN-2:0], 1'b1};
        end else begin
          rem            <= div_shift;
          acc[XLEN-1:0]  <= {acc[XLEN-2:0], 1'b0};
        end
      end else begin
        if (acc[0]) acc <= {mul_sum, acc[XLEN-1:1]};
        else        acc <= {1'b0, acc[2*XLEN-1:1]};
      end
    end else if (state == FIXUP && !flush) begin
      result <= fixup_res;
    end
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_result = result;

endmodule

// File: tb/tb_rexta_muldiv.sv
module tb_rexta_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;

  int n_checks = 0;
  int n_pass   = 0;

  rexta_muldiv #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, obs, exp);
  endtask

  // Reference: RV32M semantics via wide integer arithmetic
  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] prod;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'b000: begin prod = sa * sb; return prod[31:0]; end
      3'b001: begin prod = sa * sb; return prod[63:32]; end
      3'b010: begin prod = sa * ub; return prod[63:32]; end
      3'b011: begin prod = {32'd0, a} * {32'd0, b}; return prod[63:32]; end
      3'b100: if (b == 0) return 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
              else return 32'(ia / ib);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: if (b == 0) return a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
              else return 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, check latency, result, backpressure hold and handshake
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    int          lat;
    logic [31:0] exp, held;
    exp = model(op, a, b);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), is_special(op, a, b) ? 32'd1 : 32'd34);
    check({tag, "_res"}, resp_result, exp);
    held = resp_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_v"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "_hold_r"}, resp_result, held);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, "_post_v"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_post_rdy"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_post_r"}, resp_result, exp);
  endtask

  initial begin
    int seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0, "mul_neg");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0, "rem_neg");
    run_op(3'b101, 32'd100, 32'd7, 0, "divu");
    run_op(3'b111, 32'd100, 32'd7, 0, "remu");
    run_op(3'b101, 32'd5, 32'd0, 0, "divu_z");
    run_op(3'b110, 32'd5, 32'd0, 0, "rem_z");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5, "bp_mul");
    run_op(3'b100, 32'd9, 32'd0, 5, "bp_divz");

    // Flush at BUSY cycle 10 with a competing request
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'd11; req_b = 32'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 3'b101; req_a = 32'd50; req_b = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    check("flush_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid || !req_ready) seen++;
    end
    check("flush_quiet", 32'(seen), 32'd0);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b011; req_a = 32'hFFFF_0000; req_b = 32'h0000_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_result", resp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 32'd3, 32'd4, 0, "mul_after_rst");

    // Randomized ops including boundary operands
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'd0};
        default: ;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
